// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchroniser and mid-bit start
// qualification. Emits one-cycle valid / framing_error strobes. A held-low line
// is parked in BREAK so that it does not decode as repeated 0x00 frames.
// BAUD_DIVISOR (CLOCK_FREQUENCY / BAUD_RATE) must be at least 4.
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_DIVISOR = BAUD_DIVISOR / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIVISOR - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_DIVISOR - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA_BITS,
        STOP,
        BREAK
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  sync_reg;
    logic        rx_s;
    logic [15:0] count_reg, count_next;
    logic [2:0]  bit_index_reg, bit_index_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  data_reg, data_next;
    logic        valid_reg, valid_next;
    logic        framing_error_reg, framing_error_next;

    // The older stage is the only version of the pin the FSM ever looks at.
    assign rx_s = sync_reg[1];

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            count_reg         <= 16'd0;
            bit_index_reg     <= 3'd0;
            shift_reg         <= 8'h00;
            data_reg          <= 8'h00;
            valid_reg         <= 1'b0;
            framing_error_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            count_reg         <= count_next;
            bit_index_reg     <= bit_index_next;
            shift_reg         <= shift_next;
            data_reg          <= data_next;
            valid_reg         <= valid_next;
            framing_error_reg <= framing_error_next;
        end
    end

    // Next-state logic: the baud counter restarts from zero on every state entry.
    always_comb begin
        state_next         = state_reg;
        count_next         = count_reg;
        bit_index_next     = bit_index_reg;
        shift_next         = shift_reg;
        data_next          = data_reg;
        valid_next         = 1'b0;
        framing_error_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    count_next = 16'd0;
                end
            end

            START: begin
                if (count_reg == HALF_LAST) begin
                    count_next = 16'd0;
                    if (!rx_s) begin
                        state_next     = DATA_BITS;
                        bit_index_next = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: treat as a glitch.
                        state_next = IDLE;
                    end
                end else begin
                    count_next = count_reg + 16'd1;
                end
            end

            DATA_BITS: begin
                if (count_reg == BAUD_LAST) begin
                    count_next     = 16'd0;
                    shift_next     = {rx_s, shift_reg[7:1]};
                    bit_index_next = bit_index_reg + 3'd1;
                    if (bit_index_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    count_next = count_reg + 16'd1;
                end
            end

            STOP: begin
                if (count_reg == BAUD_LAST) begin
                    count_next = 16'd0;
                    if (rx_s) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        framing_error_next = 1'b1;
                        state_next         = BREAK;
                    end
                end else begin
                    count_next = count_reg + 16'd1;
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                    count_next = 16'd0;
                end
            end

            default: begin
                state_next = IDLE;
                count_next = 16'd0;
            end
        endcase
    end

    assign data          = data_reg;
    assign valid         = valid_reg;
    assign framing_error = framing_error_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized frames against a frame-level scoreboard
// model of the receiver, plus hand-written glitch, break and reset-abort sequences.
module tb_uart_rx;

    localparam int CLK_HZ = 27000000;
    localparam int BAUD   = 115200;
    localparam int B      = CLK_HZ / BAUD;
    localparam int LAT    = (B / 2) + 9 * B + 3;
    localparam int FRAME  = 10 * B;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;

    uart_rx #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE(BAUD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .valid(valid),
        .framing_error(framing_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        total++;
        if (actual >= lo && actual <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    endtask

    // Reference model: each complete frame on the line predicts one strobe.
    typedef struct {
        bit         is_fe;
        logic [7:0] val;
    } event_t;

    event_t     exp_q[$];
    logic [7:0] model_last_good = 8'h00;

    task automatic expect_frame(input logic [9:0] line);
        event_t     e;
        logic [7:0] decoded;
        decoded = 8'h00;
        for (int i = 0; i < 8; i++) decoded = decoded + (8'(line[i + 1]) << i);
        if (line[9]) begin
            e.is_fe = 1'b0;
            e.val   = decoded;
            model_last_good = decoded;
        end else begin
            e.is_fe = 1'b1;
            e.val   = model_last_good;
        end
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input bit is_fe, input logic [7:0] d);
        event_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("strobe_kind", int'(is_fe), int'(e.is_fe));
            check("strobe_data", int'(d), int'(e.val));
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int   valid_count = 0;
    int   fe_count    = 0;
    int   last_valid_cycle = 0;
    int   overlap_err = 0;
    int   repeat_err  = 0;
    logic prev_valid  = 1'b0;
    logic prev_fe     = 1'b0;

    always @(negedge clk) begin
        if (valid && framing_error) overlap_err++;
        if ((valid && prev_valid) || (framing_error && prev_fe)) repeat_err++;
        if (valid) begin
            valid_count++;
            last_valid_cycle = cycle;
            sb_check(1'b0, data);
        end
        if (framing_error) begin
            fe_count++;
            sb_check(1'b1, data);
        end
        prev_valid = valid;
        prev_fe    = framing_error;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] val, input bit stop);
        logic [9:0] line;
        line = {stop, val, 1'b0};
        expect_frame(line);
        for (int i = 0; i < 10; i++) begin
            rx = line[i];
            wait_cycles(B);
        end
    endtask

    // Release a held-low line and give the receiver a bounded time to go idle.
    task automatic release_line(input string name);
        int w;
        rx = 1'b1;
        w  = 0;
        while (busy && w < 10) begin
            wait_cycles(1);
            w++;
        end
        check(name, int'(busy), 0);
    endtask

    typedef struct {
        logic [7:0] val;
        bit         stop;
        int         hold;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int         v0, f0, t0, w;
        int         vc[3];
        int         busy_hi;
        logic [7:0] rval;
        bit         rstop;

        vecs[0] = '{8'hA5, 1'b1, 0,    8'hA5, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 0,    8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0,    8'hFF, 1, 0};
        vecs[3] = '{8'h81, 1'b0, 5000, 8'hFF, 0, 1};
        vecs[4] = '{8'h42, 1'b1, 0,    8'h42, 1, 0};
        vecs[5] = '{8'hC3, 1'b1, 0,    8'hC3, 1, 0};

        // Reset then long idle.
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_fe", int'(framing_error), 0);
        check("reset_busy", int'(busy), 0);
        busy_hi = 0;
        for (int i = 0; i < 5000; i++) begin
            wait_cycles(1);
            if (busy) busy_hi++;
        end
        check("idle_busy_cycles", busy_hi, 0);
        check("idle_valid_count", valid_count, 0);
        check("idle_data", int'(data), 0);

        // Table-driven frames, including a framing error followed by a held break.
        for (int i = 0; i < 6; i++) begin
            v0 = valid_count;
            f0 = fe_count;
            t0 = cycle;
            send_frame(vecs[i].val, vecs[i].stop);
            if (vecs[i].stop) begin
                check_range($sformatf("latency_%0d", i), last_valid_cycle - t0, LAT - 1, LAT + 1);
            end else begin
                rx = 1'b0;
                wait_cycles(vecs[i].hold);
                check($sformatf("break_busy_%0d", i), int'(busy), 1);
                release_line($sformatf("break_release_%0d", i));
            end
            idle(20);
            check($sformatf("vec_valid_%0d", i), valid_count - v0, vecs[i].exp_valid);
            check($sformatf("vec_fe_%0d", i), fe_count - f0, vecs[i].exp_fe);
            check($sformatf("vec_data_%0d", i), int'(data), int'(vecs[i].exp_data));
        end

        // Back-to-back frames with no idle gap.
        idle(10);
        v0 = valid_count;
        send_frame(8'h00, 1'b1); vc[0] = last_valid_cycle;
        send_frame(8'hFF, 1'b1); vc[1] = last_valid_cycle;
        send_frame(8'h55, 1'b1); vc[2] = last_valid_cycle;
        check("b2b_valid_count", valid_count - v0, 3);
        check_range("b2b_spacing_1", vc[1] - vc[0], FRAME - 1, FRAME + 1);
        check_range("b2b_spacing_2", vc[2] - vc[1], FRAME - 1, FRAME + 1);
        check("b2b_data", int'(data), 8'h55);

        // Start-bit glitch.
        idle(10);
        v0 = valid_count;
        f0 = fe_count;
        rx = 1'b0;
        wait_cycles(50);
        check("glitch_busy_high", int'(busy), 1);
        rx = 1'b1;
        w  = 0;
        while (busy && w < 120) begin
            wait_cycles(1);
            w++;
        end
        check("glitch_busy_drop", int'(busy), 0);
        idle(50);
        check("glitch_no_valid", valid_count - v0, 0);
        check("glitch_no_fe", fe_count - f0, 0);
        send_frame(8'h3C, 1'b1);
        check("glitch_next_data", int'(data), 8'h3C);
        check("glitch_next_valid", valid_count - v0, 1);

        // Reset in the middle of data bit 4 of 0x7E.
        idle(10);
        v0 = valid_count;
        f0 = fe_count;
        rval = 8'h7E;
        rx = 1'b0;
        wait_cycles(B);
        for (int i = 0; i < 4; i++) begin
            rx = rval[i];
            wait_cycles(B);
        end
        rx = rval[4];
        wait_cycles(B / 2);
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        model_last_good = 8'h00;
        check("abort_data", int'(data), 0);
        check("abort_busy", int'(busy), 0);
        idle(300);
        check("abort_no_valid", valid_count - v0, 0);
        check("abort_no_fe", fe_count - f0, 0);
        send_frame(8'h99, 1'b1);
        check("abort_next_data", int'(data), 8'h99);
        check("abort_next_valid", valid_count - v0, 1);

        // Randomized frames, some with a low stop bit and a short break.
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 40));
            rval  = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            v0 = valid_count;
            f0 = fe_count;
            send_frame(rval, rstop);
            if (!rstop) begin
                rx = 1'b0;
                wait_cycles($urandom_range(50, 300));
                release_line($sformatf("rand_release_%0d", i));
                idle(5);
            end
            check($sformatf("rand_valid_%0d", i), valid_count - v0, rstop ? 1 : 0);
            check($sformatf("rand_fe_%0d", i), fe_count - f0, rstop ? 0 : 1);
            check($sformatf("rand_data_%0d", i), int'(data), int'(model_last_good));
        end

        idle(10);
        check("pending_expected_strobes", exp_q.size(), 0);
        check("valid_fe_overlap", overlap_err, 0);
        check("strobe_longer_than_one", repeat_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the board's UART transmitter. Shares the same CLOCK_FREQUENCY/BAUD_RATE parameterisation.
- Synchronises the asynchronous rx pin, qualifies the start bit at mid-bit, and samples data LSB-first at bit centres.
- Presents each received byte as a one-cycle valid strobe; flags framing errors and line-break conditions.
- Sits between the board UART pin and user logic, e.g. an echo or command parser.

Parameters:
- CLOCK_FREQUENCY, 27000000, system clock in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- Derived localparam BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE (integer division; 234 at defaults). Must be >= 4.
- Derived localparam HALF_DIVISOR = BAUD_DIVISOR / 2 (117 at defaults).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial input; idle high.
- data  output  8  last received byte; holds its value until the next good byte.
- valid  output  1  one-cycle strobe, high in the cycle data is updated.
- framing_error  output  1  one-cycle strobe when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, baud counter=0, bit index=0, shift register=0.
  - data=8'h00, valid=0, framing_error=0, busy=0.
  - Both synchroniser flops set to 1 (idle line).
  - Reset aborts any frame in progress; no strobe is emitted.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only. rx_s lags the pin by 2 cycles.
- Baud counter: 16 bits. Cleared on every state entry.
- State machine:
  - IDLE: if rx_s==0, go to START with counter=0.
  - START: count to HALF_DIVISOR-1. At terminal count:
    - rx_s==0: go to DATA with counter=0 and bit index=0.
    - rx_s==1: glitch; return to IDLE with no strobe.
  - DATA: count to BAUD_DIVISOR-1. At terminal count:
    - Shift rx_s in MSB-side (shift_reg <= {rx_s, shift_reg[7:1]}), giving LSB-first assembly.
    - Increment bit index. After the 8th sample, go to STOP.
  - STOP: count to BAUD_DIVISOR-1. At terminal count:
    - rx_s==1: data <= shift register, valid=1 for one cycle, go to IDLE.
    - rx_s==0: framing_error=1 for one cycle, data unchanged, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This blocks a held-low line from being decoded as repeated 0x00 frames.
- Sample points: each data bit and the stop bit are sampled BAUD_DIVISOR cycles after the previous sample, i.e. at bit centre ±1 cycle.
- Latency:
  - valid asserts (HALF_DIVISOR + 9*BAUD_DIVISOR + 3) ± 1 cycles after the rx falling edge; at defaults that is 2226 ± 1.
  - Back-to-back frames are accepted: after valid, IDLE detects the next start edge immediately. The remaining half stop bit is not required.
- valid and framing_error are never high in the same cycle. Neither is ever high for more than one consecutive cycle.
- busy is combinational from state (state != IDLE).

Test Plan:
- Reset then idle: rst high 2 cycles, rx=1 for 5000 cycles -> data=0x00, valid never asserts, busy=0 throughout.
- Single frame: send 0xA5 at 234 cycles/bit (start, bits 1,0,1,0,0,1,0,1, stop) -> exactly one valid pulse, data=0xA5, framing_error=0, valid 2226±1 cycles after the start edge.
- Back-to-back frames: send 0x00, 0xFF, 0x55 with no idle gap -> three valid pulses, data 0x00, 0xFF, 0x55 in order, spaced 2340±1 cycles apart.
- Start glitch: rx low for 50 cycles, then high -> returns to IDLE, busy drops within 120 cycles, no strobe; a following 0x3C frame is received correctly.
- Framing error and break: send 0x81 with a low stop bit, then hold rx low for 5000 cycles, then release -> one framing_error pulse, no valid, data keeps its previous value, busy stays high until rx rises; a subsequent 0x42 frame is received.
- Reset mid-frame: assert rst during DATA bit 4 of 0x7E, then send 0x99 -> no strobe for the aborted frame, data=0x00 after reset, then valid with data=0x99.
